// File: rtl/request_register.sv
// request_register: pending-request store for the elevator controller.
// Edge-detects hall up/down and cabin floor buttons, holds one pending bit per
// button until the cabin serves that floor, and derives a request count and a
// request-at-current-floor flag from the stored vectors.
// Optional feature: define REQ_BTN_SYNC_EN to pass every button input through
// a two-flop synchronizer before edge detection (press latency becomes three
// cycles). Without it, buttons must already be synchronous to clk.
module request_register #(
   parameter int MAX_FLOOR = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] upButton,
   input  logic [7:0] downButton,
   input  logic [7:0] floorButton,
   input  logic [2:0] floor,
   input  logic       arrive,
   input  logic       serveUp,
   input  logic       serveDown,
   output logic [7:0] upRequest,
   output logic [7:0] downRequest,
   output logic [7:0] floorRequest,
   output logic       anyRequest,
   output logic       hereRequest,
   output logic [4:0] pendingCount
);

   // Bits that may ever be set: floors below MAX_FLOOR, no up call at the top
   // floor, no down call at the bottom floor.
   localparam logic [7:0] VALID_MASK = 8'((9'd1 << MAX_FLOOR) - 9'd1);
   localparam logic [7:0] UP_MASK    = VALID_MASK & ~(8'd1 << (MAX_FLOOR - 1));
   localparam logic [7:0] DOWN_MASK  = VALID_MASK & 8'hFE;
   localparam logic [3:0] FLOOR_LIM  = 4'(MAX_FLOOR);

   logic [7:0] up_btn, down_btn, floor_btn;
   logic [7:0] up_prev_q, down_prev_q, floor_prev_q;
   logic [7:0] up_q, down_q, floor_q;
   logic [7:0] up_d, down_d, floor_d;
   logic [7:0] clr_vec;
   logic [4:0] count_v;

`ifdef REQ_BTN_SYNC_EN
   logic [23:0] sync1_q, sync2_q;

   // Two-flop synchronizer on all 24 raw button inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {upButton, downButton, floorButton};
         sync2_q <= sync1_q;
      end
   end

   assign {up_btn, down_btn, floor_btn} = sync2_q;
`else
   assign up_btn    = upButton;
   assign down_btn  = downButton;
   assign floor_btn = floorButton;
`endif

   // Clear vector: one-hot on the arrival floor, empty for out-of-range floors.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      clr_vec = '0;
      if (arrive && ({1'b0, floor} < FLOOR_LIM)) begin
         clr_vec[floor] = 1'b1;
      end
   end

   // Next-state request vectors: rising-edge presses set, arrivals clear, and
   // clear is applied last so it wins a same-cycle collision.
   always_comb begin
      up_d    = (up_q    | (up_btn    & ~up_prev_q    & UP_MASK))
                & ~(serveUp   ? clr_vec : 8'h00);
      down_d  = (down_q  | (down_btn  & ~down_prev_q  & DOWN_MASK))
                & ~(serveDown ? clr_vec : 8'h00);
      floor_d = (floor_q | (floor_btn & ~floor_prev_q & VALID_MASK))
                & ~clr_vec;
   end

   // State registers: previous button values and pending request vectors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_prev_q    <= '0;
         down_prev_q  <= '0;
         floor_prev_q <= '0;
         up_q         <= '0;
         down_q       <= '0;
         floor_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so prev and request update from the same snapshot.
         up_prev_q    <= up_btn;
         down_prev_q  <= down_btn;
         floor_prev_q <= floor_btn;
         up_q         <= up_d;
         down_q       <= down_d;
         floor_q      <= floor_d;
      end
   end

   // Popcount over all 24 stored request bits.
   always_comb begin
      count_v = '0;
      for (int i = 0; i < 8; i++) begin
         count_v = count_v + {4'b0, up_q[i]} + {4'b0, down_q[i]}
                           + {4'b0, floor_q[i]};
      end
   end

   assign upRequest    = up_q;
   assign downRequest  = down_q;
   assign floorRequest = floor_q;
   assign anyRequest   = |{up_q, down_q, floor_q};
   assign hereRequest  = floor_q[floor] | up_q[floor] | down_q[floor];
   assign pendingCount = count_v;

endmodule

// File: tb/tb_request_register.sv
// Testbench for request_register: directed scenarios followed by random
// traffic, all checked against a per-floor behavioural model.
module tb_request_register;

   localparam int MF = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] upButton, downButton, floorButton;
   logic [2:0] floor;
   logic       arrive, serveUp, serveDown;
   logic [7:0] upRequest, downRequest, floorRequest;
   logic       anyRequest, hereRequest;
   logic [4:0] pendingCount;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: pending bits and last button values seen by edge detection.
   bit [7:0] m_up, m_dn, m_fl;
   bit [7:0] p_up, p_dn, p_fl;
   bit [7:0] s1_up, s1_dn, s1_fl, s2_up, s2_dn, s2_fl;

   always #5 clk = ~clk;

   request_register #(.MAX_FLOOR(MF)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .upButton     (upButton),
      .downButton   (downButton),
      .floorButton  (floorButton),
      .floor        (floor),
      .arrive       (arrive),
      .serveUp      (serveUp),
      .serveDown    (serveDown),
      .upRequest    (upRequest),
      .downRequest  (downRequest),
      .floorRequest (floorRequest),
      .anyRequest   (anyRequest),
      .hereRequest  (hereRequest),
      .pendingCount (pendingCount)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_up = '0; m_dn = '0; m_fl = '0;
      p_up = '0; p_dn = '0; p_fl = '0;
      s1_up = '0; s1_dn = '0; s1_fl = '0;
      s2_up = '0; s2_dn = '0; s2_fl = '0;
   endtask

   // One clock edge of the request rules, applied floor by floor.
   task automatic model_edge();
      bit [7:0] bu, bd, bf;
`ifdef REQ_BTN_SYNC_EN
      bu = s2_up; bd = s2_dn; bf = s2_fl;
      s2_up = s1_up; s2_dn = s1_dn; s2_fl = s1_fl;
      s1_up = upButton; s1_dn = downButton; s1_fl = floorButton;
`else
      bu = upButton; bd = downButton; bf = floorButton;
`endif
      for (int f = 0; f < 8; f++) begin
         bit served_here;
         served_here = arrive && (int'(floor) == f) && (f < MF);
         if (bu[f] && !p_up[f] && f < MF && f != MF - 1) m_up[f] = 1'b1;
         if (bd[f] && !p_dn[f] && f < MF && f != 0)      m_dn[f] = 1'b1;
         if (bf[f] && !p_fl[f] && f < MF)                m_fl[f] = 1'b1;
         if (served_here && serveUp)   m_up[f] = 1'b0;
         if (served_here && serveDown) m_dn[f] = 1'b0;
         if (served_here)              m_fl[f] = 1'b0;
      end
      p_up = bu; p_dn = bd; p_fl = bf;
   endtask

   task automatic check_all(input string tag);
      int cnt;
      cnt = 0;
      for (int f = 0; f < 8; f++) cnt += int'(m_up[f]) + int'(m_dn[f]) + int'(m_fl[f]);
      check({tag, ".up"},    32'(upRequest),    32'(m_up));
      check({tag, ".down"},  32'(downRequest),  32'(m_dn));
      check({tag, ".floor"}, 32'(floorRequest), 32'(m_fl));
      check({tag, ".any"},   32'(anyRequest),   32'(cnt != 0));
      check({tag, ".here"},  32'(hereRequest),
            32'(m_up[floor] | m_dn[floor] | m_fl[floor]));
      check({tag, ".count"}, 32'(pendingCount), 32'(cnt));
   endtask

   // Drive one cycle of inputs at the falling edge, step the model on the
   // rising edge, compare shortly after it.
   task automatic cycle(input string tag, input logic [7:0] u, input logic [7:0] d,
                        input logic [7:0] fb, input logic [2:0] flr,
                        input logic arr, input logic su, input logic sd);
      @(negedge clk);
      upButton = u; downButton = d; floorButton = fb;
      floor = flr; arrive = arr; serveUp = su; serveDown = sd;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      upButton = '0; downButton = '0; floorButton = '0;
      floor = '0; arrive = 1'b0; serveUp = 1'b0; serveDown = 1'b0;
      model_reset();
      #1;
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      upButton = '0; downButton = '0; floorButton = '0;
      floor = '0; arrive = 1'b0; serveUp = 1'b0; serveDown = 1'b0;
      model_reset();

      // Reset and single press.
      do_reset("reset");
      cycle("press", 8'h00, 8'h00, 8'h20, 3'd0, 1'b0, 1'b0, 1'b0);
`ifndef REQ_BTN_SYNC_EN
      check("press.floor_const", 32'(floorRequest), 32'h20);
      check("press.count_const", 32'(pendingCount), 32'd1);
      check("press.any_const",   32'(anyRequest),   32'd1);
`endif
      cycle("press_rel", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

      // Held button served at cycle 5 stays cleared while still held.
      do_reset("reset_held");
      for (int k = 0; k < 10; k++) begin
         cycle("held", 8'h04, 8'h00, 8'h00, 3'd2, k == 4, 1'b1, 1'b0);
`ifndef REQ_BTN_SYNC_EN
         check("held.up2_const", 32'(upRequest[2]), 32'(k < 4));
`endif
      end
      cycle("held_rel", 8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0);

      // Masked presses at the top and bottom floors.
      do_reset("reset_mask");
      cycle("mask", 8'h80, 8'h01, 8'h80, 3'd7, 1'b0, 1'b0, 1'b0);
      cycle("mask2", 8'h00, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
      cycle("mask3", 8'h00, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
`ifndef REQ_BTN_SYNC_EN
      check("mask.floor_const", 32'(floorRequest), 32'h80);
      check("mask.up_const",    32'(upRequest),    32'h00);
      check("mask.count_const", 32'(pendingCount), 32'd1);
`endif

      // Partial clear: only the down call and cabin request at floor 3 go.
      do_reset("reset_partial");
      cycle("partial_set", 8'h08, 8'h08, 8'h08, 3'd3, 1'b0, 1'b0, 1'b0);
      cycle("partial_rel", 8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);
      cycle("partial_rel2", 8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);
      cycle("partial_rel3", 8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);
      cycle("partial_clr", 8'h00, 8'h00, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1);
`ifndef REQ_BTN_SYNC_EN
      check("partial.up_const",    32'(upRequest),    32'h08);
      check("partial.here_const",  32'(hereRequest),  32'd1);
      check("partial.count_const", 32'(pendingCount), 32'd1);
`endif

      // Collision: press and arrival on the same floor in the same cycle.
      do_reset("reset_coll");
      cycle("coll_pre", 8'h00, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
      cycle("coll", 8'h00, 8'h00, 8'h11, 3'd4, 1'b1, 1'b0, 1'b0);
`ifndef REQ_BTN_SYNC_EN
      check("coll.floor4_const", 32'(floorRequest[4]), 32'd0);
      check("coll.count_const",  32'(pendingCount),    32'd1);
`endif
      cycle("coll_hold", 8'h00, 8'h00, 8'h11, 3'd4, 1'b0, 1'b0, 1'b0);
      cycle("coll_hold2", 8'h00, 8'h00, 8'h11, 3'd4, 1'b0, 1'b0, 1'b0);
      cycle("coll_hold3", 8'h00, 8'h00, 8'h11, 3'd4, 1'b0, 1'b0, 1'b0);

      // Reset mid-operation with six requests pending.
      do_reset("reset_mid_pre");
      cycle("mid_set", 8'h07, 8'h00, 8'h07, 3'd1, 1'b0, 1'b0, 1'b0);
      cycle("mid_rel", 8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0);
      cycle("mid_rel2", 8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0);
      cycle("mid_rel3", 8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0);
      check("mid.count_const", 32'(pendingCount), 32'd6);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("mid_reset");
      check("mid.count_zero", 32'(pendingCount), 32'd0);

      // Button held across reset release counts as a press.
      @(negedge clk);
      floorButton = 8'h02;
      @(negedge clk);
      rst_n = 1'b1;
      cycle("held_rst", 8'h00, 8'h00, 8'h02, 3'd1, 1'b0, 1'b0, 1'b0);
      cycle("held_rst2", 8'h00, 8'h00, 8'h02, 3'd1, 1'b0, 1'b0, 1'b0);
      cycle("held_rst3", 8'h00, 8'h00, 8'h02, 3'd1, 1'b0, 1'b0, 1'b0);
      check("held_rst.floor1", 32'(floorRequest[1]), 32'd1);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         logic [7:0] ru, rd, rf;
         logic [2:0] rfl;
         logic       ra;
         ru  = 8'($urandom & $urandom);
         rd  = 8'($urandom & $urandom);
         rf  = 8'($urandom & $urandom);
         rfl = 3'($urandom_range(0, 7));
         ra  = ($urandom_range(0, 3) == 0);
         cycle("rand", ru, rd, rf, rfl, ra, 1'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/request_register.md
# request_register

Sequential request store for the elevator controller. It edge-detects the hall up/down buttons and the cabin floor buttons, then holds one pending bit per button until the cabin serves that floor. Its registered vectors `upRequest`, `downRequest` and `floorRequest` are the inputs consumed by the request-solving logic that decides travel direction. It also reports a pending-request count and whether a request exists at the current floor.

## Interface
- `MAX_FLOOR`, default 8: number of valid floors, range 2..8. Vectors are fixed at 8 bits; bits at or above `MAX_FLOOR` are never set.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `upButton`  in  8  raw hall up-call buttons, level, one per floor.
- `downButton`  in  8  raw hall down-call buttons, level, one per floor.
- `floorButton`  in  8  raw cabin floor buttons, level.
- `floor`  in  3  current cabin floor.
- `arrive`  in  1  one-cycle pulse: cabin has stopped at `floor` and the doors are opening.
- `serveUp`  in  1  qualifies `arrive`: the cabin departs upward, so the up call at `floor` is served.
- `serveDown`  in  1  qualifies `arrive`: the cabin departs downward, so the down call at `floor` is served.
- `upRequest`  out  8  pending up calls, registered.
- `downRequest`  out  8  pending down calls, registered.
- `floorRequest`  out  8  pending cabin requests, registered.
- `anyRequest`  out  1  OR of all three vectors.
- `hereRequest`  out  1  `floorRequest[floor] | upRequest[floor] | downRequest[floor]`.
- `pendingCount`  out  5  popcount of all three vectors, range 0..22.

## Operation
- **Edge detection.**
  - Each button input has a previous-value register, reset to 0.
  - A press is a rising edge: current = 1 and previous = 0.
  - Holding a button produces exactly one press.
- **Set.** A press on bit i sets the corresponding request bit, except for these masked bits:
  - `upRequest[MAX_FLOOR-1]` is never set (top floor has no up call).
  - `downRequest[0]` is never set (bottom floor has no down call).
  - Any bit i ≥ `MAX_FLOOR`, in all vectors, is never set.
  - Masked presses are ignored.
- **Clear.** On an `arrive` cycle with `floor < MAX_FLOOR`:
  - `floorRequest[floor]` is always cleared.
  - `upRequest[floor]` is cleared if `serveUp` = 1.
  - `downRequest[floor]` is cleared if `serveDown` = 1.
  - `serveUp` and `serveDown` may both be 1 (idle cabin serves both calls).
- **Ignored arrivals.** An `arrive` cycle with `floor ≥ MAX_FLOOR` is ignored entirely.
- **Simultaneous set and clear on the same bit:** clear wins, and the bit is 0 next cycle. The press is consumed and does not re-set the bit later, even if the button stays held.
- **Other bits** are unaffected; any number of bits may set in one cycle.
- **Derived outputs.**
  - `anyRequest` and `pendingCount` are combinational from the registered vectors, so they are always consistent with them in the same cycle.
  - `hereRequest` is combinational from the registered vectors and the live `floor` input.
- **Reset.**
  - All request vectors are 0; `anyRequest` = 0, `hereRequest` = 0, `pendingCount` = 0; edge registers are 0.
  - Asserting reset mid-operation drops all pending requests immediately.
  - A button already held when reset releases counts as a press on the first clock after release.

## Timing
- **Press latency** (macro undefined): a button rising at sample edge n sets its request bit, visible after edge n (one cycle).
- **Clear latency:** an `arrive` sampled at edge n clears the bit, visible after edge n.
- **Cadence:** there is no handshake back to the controller. `arrive` must be a single-cycle pulse per stop; holding it high re-clears every cycle, which is harmless.
- **Derived outputs:** `anyRequest`, `hereRequest` and `pendingCount` have zero additional latency relative to the vectors.

## Configuration
- **`REQ_BTN_SYNC_EN` defined:**
  - Each of the 24 button inputs passes through a two-flop synchronizer, reset to 0, before edge detection.
  - Press latency becomes three cycles.
  - Clear-wins arbitration applies to the synchronized edge.
- **`REQ_BTN_SYNC_EN` undefined:**
  - Buttons feed edge detection directly.
  - Press latency is one cycle.
  - Inputs must already be synchronous to `clk`.

## Test plan
- **Reset and press.** Reset, then pulse `floorButton` = 8'h20 for one cycle → after one cycle `floorRequest` = 8'h20, `pendingCount` = 1, `anyRequest` = 1.
- **Held button.** Hold `upButton[2]` high for 10 cycles; `arrive` with `floor` = 2, `serveUp` = 1 at cycle 5 → `upRequest[2]` is 1, then 0 from cycle 6 and stays 0 while held.
- **Masking.** Press `upButton[7]`, `downButton[0]` and `floorButton[7]` with `MAX_FLOOR` = 8 → only `floorRequest[7]` is set; `pendingCount` = 1.
- **Partial clear.** Set `upRequest[3]`, `downRequest[3]` and `floorRequest[3]`; `arrive` at `floor` = 3 with `serveDown` = 1 only → only `upRequest[3]` remains; `hereRequest` = 1; `pendingCount` = 1.
- **Collision.** Press `floorButton[4]` in the same cycle as an `arrive` at `floor` = 4 → `floorRequest[4]` = 0 next cycle; `pendingCount` is unchanged.
- **Reset mid-operation.** Assert `rst_n` low mid-operation with 6 requests pending → all outputs are 0 immediately, before the next clock edge.
